// File: rtl/mario_control.sv
// Purpose: game control FSM sequencing level entry, per-frame erase/move/commit/redraw and jump/fall timing.
// Latency: tick -> erase request 1 cycle; draw_done -> motion strobe 1 cycle; strobe -> redraw request 2 cycles.
// Backpressure: each drawer pass holds draw_req until draw_done; frame ticks outside WAIT are dropped.
module mario_control #(
  parameter int unsigned JUMP_HEIGHT = 20
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_go,
  input  logic i_right,
  input  logic i_left,
  input  logic i_up,
  input  logic i_ground,
  input  logic i_outofBounds,
  input  logic i_pipe,
  input  logic i_next,
  input  logic i_flag,
  input  logic i_dead,
  input  logic i_draw_done,
  output logic o_start,
  output logic o_lvl1,
  output logic o_lvl2,
  output logic o_lvl3,
  output logic o_drStage1,
  output logic o_drStage2,
  output logic o_drStage3,
  output logic o_erM,
  output logic o_jumping,
  output logic o_falling,
  output logic o_draw_req,
  output logic o_erase,
  output logic o_win
);

  typedef enum logic [3:0] {
    S_START,
    S_INIT,
    S_DRAW0,
    S_WAIT,
    S_ERASE,
    S_STEP,
    S_COMMIT,
    S_DRAW,
    S_WIN
  } state_t;

  typedef enum logic [1:0] {
    M_JUMP,
    M_FALL,
    M_WALK
  } motion_t;

  localparam logic [4:0] JH = 5'(JUMP_HEIGHT);

  state_t      r_state;
  state_t      w_state_nxt;
  motion_t     r_motion;
  motion_t     w_motion_nxt;
  logic [1:0]  r_level;
  logic [1:0]  w_level_nxt;
  logic [4:0]  r_jcnt;
  logic [4:0]  w_jcnt_nxt;
  // Low during reset and for the first cycle of the reset edge so no strobe fires while held in reset.
  logic        r_live;
  logic        w_bump;
  logic [4:0]  w_jcnt_eff;

  // A head bump (airborne and out of bounds) cancels the remaining rise; the same tick already sees it.
  assign w_bump     = (r_state == S_WAIT) && !i_ground && i_outofBounds && (r_jcnt != 5'd0);
  assign w_jcnt_eff = w_bump ? 5'd0 : r_jcnt;

  // State, level, jump counter and motion registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state  <= S_START;
      r_level  <= 2'd1;
      r_jcnt   <= 5'd0;
      r_motion <= M_WALK;
      r_live   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_level  <= w_level_nxt;
      r_jcnt   <= w_jcnt_nxt;
      r_motion <= w_motion_nxt;
      r_live   <= 1'b1;
    end
  end

  // Next-state, level, jump counter and motion selection.
  always_comb begin
    w_state_nxt  = r_state;
    w_level_nxt  = r_level;
    w_jcnt_nxt   = r_jcnt;
    w_motion_nxt = r_motion;
    case (r_state)
      // START holds until out of reset so its one-cycle strobe is visible after release.
      S_START: begin
        if (r_live) w_state_nxt = S_INIT;
      end
      S_INIT: begin
        w_jcnt_nxt  = 5'd0;
        w_state_nxt = S_DRAW0;
      end
      S_DRAW0, S_DRAW: begin
        if (i_draw_done) w_state_nxt = S_WAIT;
      end
      S_ERASE: begin
        if (i_draw_done) w_state_nxt = S_STEP;
      end
      S_WAIT: begin
        if (w_bump) w_jcnt_nxt = 5'd0;
        if (i_go) begin
          if (i_dead && (r_level == 2'd1)) begin
            w_level_nxt = 2'd1;
            w_state_nxt = S_START;
          end else if (i_flag && (r_level == 2'd3)) begin
            w_state_nxt = S_WIN;
          end else if (i_next && (r_level == 2'd2)) begin
            w_level_nxt = 2'd3;
            w_state_nxt = S_START;
          end else if (i_pipe && (r_level == 2'd1)) begin
            w_level_nxt = 2'd2;
            w_state_nxt = S_START;
          end else if (w_jcnt_eff != 5'd0) begin
            w_motion_nxt = M_JUMP;
            w_state_nxt  = S_ERASE;
          end else if (i_up && i_ground) begin
            w_jcnt_nxt   = JH;
            w_motion_nxt = M_JUMP;
            w_state_nxt  = S_ERASE;
          end else if (!i_ground) begin
            w_motion_nxt = M_FALL;
            w_state_nxt  = S_ERASE;
          end else if (i_right || i_left) begin
            w_motion_nxt = M_WALK;
            w_state_nxt  = S_ERASE;
          end
        end
      end
      S_STEP: begin
        if ((r_motion == M_JUMP) && (r_jcnt != 5'd0)) w_jcnt_nxt = r_jcnt - 5'd1;
        w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_state_nxt = S_DRAW;
      end
      S_WIN: begin
        w_state_nxt = S_WIN;
      end
      default: begin
        w_state_nxt = S_START;
      end
    endcase
  end

  // Moore outputs decoded from registered state only.
  assign o_start    = r_live && (r_state == S_START);
  assign o_drStage1 = (r_state == S_INIT) && (r_level == 2'd1);
  assign o_drStage2 = (r_state == S_INIT) && (r_level == 2'd2);
  assign o_drStage3 = (r_state == S_INIT) && (r_level == 2'd3);
  assign o_jumping  = (r_state == S_STEP) && (r_motion == M_JUMP);
  assign o_falling  = (r_state == S_STEP) && (r_motion == M_FALL);
  assign o_erM      = (r_state == S_STEP) && (r_motion == M_WALK);
  assign o_draw_req = (r_state == S_DRAW0) || (r_state == S_DRAW) || (r_state == S_ERASE);
  assign o_erase    = (r_state == S_ERASE);
  assign o_win      = (r_state == S_WIN);
  assign o_lvl1     = (r_level == 2'd1);
  assign o_lvl2     = (r_level == 2'd2);
  assign o_lvl3     = (r_level == 2'd3);

endmodule

// File: tb/tb_mario_control.sv
// Directed bench for mario_control: boot, walk, jump, head bump, level progression, death and reset abort.
module tb_mario_control;

  logic clk = 1'b0;
  logic resetn, go, right, left, up, ground, outofBounds, pipe, nxt, flag, dead, draw_done;
  logic start, lvl1, lvl2, lvl3, drStage1, drStage2, drStage3;
  logic erM, jumping, falling, draw_req, erase, win;

  int n_tests = 0;
  int n_fail  = 0;
  int c_jump  = 0;
  int c_fall  = 0;
  int c_erm   = 0;

  always #5 clk = ~clk;

  mario_control #(.JUMP_HEIGHT(20)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_go(go),
    .i_right(right), .i_left(left), .i_up(up),
    .i_ground(ground), .i_outofBounds(outofBounds), .i_pipe(pipe),
    .i_next(nxt), .i_flag(flag), .i_dead(dead), .i_draw_done(draw_done),
    .o_start(start), .o_lvl1(lvl1), .o_lvl2(lvl2), .o_lvl3(lvl3),
    .o_drStage1(drStage1), .o_drStage2(drStage2), .o_drStage3(drStage3),
    .o_erM(erM), .o_jumping(jumping), .o_falling(falling),
    .o_draw_req(draw_req), .o_erase(erase), .o_win(win)
  );

  // Motion strobe pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (jumping) c_jump <= c_jump + 1;
    if (falling) c_fall <= c_fall + 1;
    if (erM)     c_erm  <= c_erm + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame tick with draw_done high: ERASE, STEP, COMMIT, DRAW, back to WAIT.
  task automatic do_frame();
    go = 1'b1;
    step();
    go = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    resetn = 1'b0; go = 0; right = 0; left = 0; up = 0; ground = 1; outofBounds = 0;
    pipe = 0; nxt = 0; flag = 0; dead = 0; draw_done = 1;
    repeat (3) step();
    n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", start); end
    n_tests++; if (draw_req !== 1'b0) begin n_fail++; $display("FAIL rst_draw_req: got %b want 0", draw_req); end
    n_tests++; if ({lvl1, lvl2, lvl3} !== 3'b100) begin n_fail++; $display("FAIL rst_lvl: got %b want 100", {lvl1, lvl2, lvl3}); end
    n_tests++; if ({win, drStage1, erM, jumping, falling} !== 5'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 00000", {win, drStage1, erM, jumping, falling}); end
    resetn = 1'b1;
    step();
    n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL boot_start: got %b want 1", start); end
    step();
    n_tests++; if ({start, drStage1} !== 2'b01) begin n_fail++; $display("FAIL boot_drstage1: got %b want 01", {start, drStage1}); end
    step();
    n_tests++; if ({draw_req, erase, drStage1} !== 3'b100) begin n_fail++; $display("FAIL boot_draw_req: got %b want 100", {draw_req, erase, drStage1}); end
    step();
    n_tests++; if (draw_req !== 1'b0) begin n_fail++; $display("FAIL boot_wait: draw_req got %b want 0", draw_req); end
  endtask

  task automatic test_idle();
    int e0;
    e0 = c_erm + c_jump + c_fall;
    go = 1'b1; step(); go = 1'b0;
    n_tests++; if ({start, draw_req} !== 2'b00) begin n_fail++; $display("FAIL idle_tick: got %b want 00", {start, draw_req}); end
    repeat (3) step();
    n_tests++; if ((c_erm + c_jump + c_fall) != e0) begin n_fail++; $display("FAIL idle_motion: got %0d strobes want 0", c_erm + c_jump + c_fall - e0); end
  endtask

  task automatic test_walk();
    int j0, f0;
    j0 = c_jump; f0 = c_fall;
    right = 1'b1; draw_done = 1'b0; go = 1'b1;
    step();
    go = 1'b0;
    n_tests++; if ({draw_req, erase, erM} !== 3'b110) begin n_fail++; $display("FAIL walk_erase: got %b want 110", {draw_req, erase, erM}); end
    step();
    n_tests++; if ({draw_req, erase} !== 2'b11) begin n_fail++; $display("FAIL walk_erase_hold: got %b want 11", {draw_req, erase}); end
    draw_done = 1'b1;
    step();
    n_tests++; if ({erM, jumping, falling, draw_req} !== 4'b1000) begin n_fail++; $display("FAIL walk_step: got %b want 1000", {erM, jumping, falling, draw_req}); end
    step();
    n_tests++; if ({erM, draw_req} !== 2'b00) begin n_fail++; $display("FAIL walk_commit: got %b want 00", {erM, draw_req}); end
    go = 1'b1;
    step();
    go = 1'b0;
    n_tests++; if ({draw_req, erase} !== 2'b10) begin n_fail++; $display("FAIL walk_draw: got %b want 10", {draw_req, erase}); end
    step();
    step();
    n_tests++; if (draw_req !== 1'b0) begin n_fail++; $display("FAIL walk_go_dropped: draw_req got %b want 0", draw_req); end
    n_tests++; if ((c_jump - j0) != 0 || (c_fall - f0) != 0) begin n_fail++; $display("FAIL walk_no_jump_fall: got %0d/%0d want 0/0", c_jump - j0, c_fall - f0); end
    right = 1'b0;
  endtask

  task automatic test_jump();
    int j0, f0;
    j0 = c_jump; f0 = c_fall;
    up = 1'b1; ground = 1'b1;
    do_frame();
    up = 1'b0; ground = 1'b0;
    repeat (19) do_frame();
    n_tests++; if ((c_jump - j0) != 20 || (c_fall - f0) != 0) begin n_fail++; $display("FAIL jump_rise: jumps %0d falls %0d want 20/0", c_jump - j0, c_fall - f0); end
    repeat (5) do_frame();
    n_tests++; if ((c_jump - j0) != 20 || (c_fall - f0) != 5) begin n_fail++; $display("FAIL jump_fall: jumps %0d falls %0d want 20/5", c_jump - j0, c_fall - f0); end
    ground = 1'b1;
  endtask

  task automatic test_head_bump();
    int j0, f0;
    j0 = c_jump; f0 = c_fall;
    up = 1'b1; ground = 1'b1;
    do_frame();
    up = 1'b0; ground = 1'b0;
    repeat (2) do_frame();
    outofBounds = 1'b1;
    step();
    do_frame();
    n_tests++; if ((c_jump - j0) != 3 || (c_fall - f0) != 1) begin n_fail++; $display("FAIL head_bump: jumps %0d falls %0d want 3/1", c_jump - j0, c_fall - f0); end
    outofBounds = 1'b0; ground = 1'b1;
  endtask

  task automatic test_levels();
    int e0;
    pipe = 1'b1; go = 1'b1;
    step();
    go = 1'b0; pipe = 1'b0;
    n_tests++; if ({start, lvl1, lvl2, lvl3} !== 4'b1010) begin n_fail++; $display("FAIL pipe_start: got %b want 1010", {start, lvl1, lvl2, lvl3}); end
    step();
    n_tests++; if ({drStage1, drStage2, drStage3} !== 3'b010) begin n_fail++; $display("FAIL pipe_drstage: got %b want 010", {drStage1, drStage2, drStage3}); end
    step(); step();
    nxt = 1'b1; go = 1'b1;
    step();
    go = 1'b0; nxt = 1'b0;
    n_tests++; if ({start, lvl1, lvl2, lvl3} !== 4'b1001) begin n_fail++; $display("FAIL next_start: got %b want 1001", {start, lvl1, lvl2, lvl3}); end
    step();
    n_tests++; if ({drStage1, drStage2, drStage3} !== 3'b001) begin n_fail++; $display("FAIL next_drstage: got %b want 001", {drStage1, drStage2, drStage3}); end
    step(); step();
    flag = 1'b1; go = 1'b1;
    step();
    go = 1'b0; flag = 1'b0;
    n_tests++; if ({win, draw_req} !== 2'b10) begin n_fail++; $display("FAIL flag_win: got %b want 10", {win, draw_req}); end
    e0 = c_erm;
    right = 1'b1; go = 1'b1;
    step();
    go = 1'b0;
    repeat (3) step();
    n_tests++; if ({win, start, draw_req} !== 3'b100 || c_erm != e0) begin n_fail++; $display("FAIL win_hold: got %b erM %0d want 100 erM 0", {win, start, draw_req}, c_erm - e0); end
    right = 1'b0;
  endtask

  task automatic test_dead_and_abort();
    resetn = 1'b0;
    step();
    n_tests++; if ({win, lvl1, lvl3} !== 3'b010) begin n_fail++; $display("FAIL win_reset: got %b want 010", {win, lvl1, lvl3}); end
    resetn = 1'b1;
    repeat (4) step();
    dead = 1'b1; go = 1'b1;
    step();
    go = 1'b0; dead = 1'b0;
    n_tests++; if ({start, lvl1} !== 2'b11) begin n_fail++; $display("FAIL dead_lvl1: got %b want 11", {start, lvl1}); end
    step();
    n_tests++; if (drStage1 !== 1'b1) begin n_fail++; $display("FAIL dead_drstage1: got %b want 1", drStage1); end
    step(); step();
    pipe = 1'b1; go = 1'b1;
    step();
    go = 1'b0; pipe = 1'b0;
    repeat (3) step();
    dead = 1'b1; go = 1'b1;
    step();
    go = 1'b0; dead = 1'b0;
    n_tests++; if ({start, draw_req, lvl2} !== 3'b001) begin n_fail++; $display("FAIL dead_lvl2_ignored: got %b want 001", {start, draw_req, lvl2}); end
    right = 1'b1; draw_done = 1'b0; go = 1'b1;
    step();
    go = 1'b0;
    step();
    n_tests++; if ({draw_req, erase} !== 2'b11) begin n_fail++; $display("FAIL abort_erase: got %b want 11", {draw_req, erase}); end
    resetn = 1'b0;
    step();
    n_tests++; if ({draw_req, start, erM, lvl1, lvl2} !== 5'b00010) begin n_fail++; $display("FAIL abort_reset: got %b want 00010", {draw_req, start, erM, lvl1, lvl2}); end
    resetn = 1'b1; right = 1'b0; draw_done = 1'b1;
    step();
    n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL abort_restart: got %b want 1", start); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_walk();
    test_jump();
    test_head_bump();
    test_levels();
    test_dead_and_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
